// File: rtl/mldsa_pkg.sv
// Shared ML-DSA constants and enums for the bounded-coefficient sampler slice.
package mldsa_pkg;
  localparam int RATE_BYTES = 136;
  localparam int Q          = 8380417;
  localparam int COEF_W     = 23;
  localparam int N_COEF     = 256;
  localparam int POLY_W     = 4;

  typedef enum logic {ETA2 = 1'b0, ETA4 = 1'b1} eta_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SAMPLE,
    S_PDONE,
    S_DONE
  } state_e;
endpackage

// File: rtl/coeff_from_half_byte.sv
// Maps one squeeze nibble to an accept flag and a coefficient in [-eta, eta] stored mod Q.
module coeff_from_half_byte
  import mldsa_pkg::*;
(
  input  logic [3:0]        i_nibble,
  input  eta_e              i_eta_sel,
  output logic              o_accept,
  output logic [COEF_W-1:0] o_value
);
  logic [3:0] w_m;
  logic [3:0] w_mag;
  logic       w_neg;

  always_comb begin
    w_m      = i_nibble;
    w_mag    = '0;
    w_neg    = 1'b0;
    o_accept = 1'b0;
    if (i_eta_sel == ETA2) begin
      o_accept = i_nibble < 4'd15;
      // Nibble is below 15 when accepted, so two subtractions give z mod 5.
      if (i_nibble >= 4'd10)     w_m = i_nibble - 4'd10;
      else if (i_nibble >= 4'd5) w_m = i_nibble - 4'd5;
      w_neg = w_m > 4'd2;
      w_mag = w_neg ? (w_m - 4'd2) : (4'd2 - w_m);
    end else begin
      o_accept = i_nibble < 4'd9;
      w_neg    = i_nibble > 4'd4;
      w_mag    = w_neg ? (i_nibble - 4'd4) : (4'd4 - i_nibble);
    end
    o_value = w_neg ? (COEF_W'(Q) - COEF_W'(w_mag)) : COEF_W'(w_mag);
  end
endmodule

// File: rtl/rej_bounded_sampler.sv
// Rejection-samples SHAKE256 blocks into ML-DSA s1/s2 coefficients (eta 2 or 4), up to
// two per byte; registered output stalls the byte walk while the beat is not accepted.
module rej_bounded_sampler
  import mldsa_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    eta_sel,
  input  logic [POLY_W-1:0]       num_polys,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [RATE_BYTES*8-1:0] blk_data,
  output logic                    coef_valid,
  input  logic                    coef_ready,
  output logic [1:0]              coef_lane_en,
  output logic [COEF_W-1:0]       coef0,
  output logic [COEF_W-1:0]       coef1,
  output logic [7:0]              coef_idx,
  output logic [POLY_W-1:0]       poly_idx,
  output logic                    poly_done,
  output logic                    busy,
  output logic                    done
);
  localparam logic [7:0] LAST_BYTE = 8'(RATE_BYTES - 1);
  localparam logic [8:0] J_FULL    = 9'(N_COEF);

  state_e                  r_state, w_next;
  logic [RATE_BYTES*8-1:0] r_blk;
  logic [7:0]              r_ptr;
  logic [8:0]              r_j;
  eta_e                    r_eta;
  logic [POLY_W-1:0]       r_npolys, r_poly_idx;
  logic                    r_coef_vld;
  logic [1:0]              r_lane_en;
  logic [COEF_W-1:0]       r_coef0, r_coef1;
  logic [7:0]              r_coef_idx;

  logic                    w_adv, w_step, w_acc0, w_acc1, w_both;
  logic [COEF_W-1:0]       w_val0, w_val1;
  logic [1:0]              w_n;
  logic [8:0]              w_j_next;

  coeff_from_half_byte u_lo (.i_nibble(r_blk[3:0]), .i_eta_sel(r_eta), .o_accept(w_acc0), .o_value(w_val0));
  coeff_from_half_byte u_hi (.i_nibble(r_blk[7:4]), .i_eta_sel(r_eta), .o_accept(w_acc1), .o_value(w_val1));

  assign w_adv  = !r_coef_vld || coef_ready;
  assign w_step = (r_state == S_SAMPLE) && w_adv;
  // At j==255 only one slot is left, so a second accepted nibble is dropped.
  assign w_both   = w_acc0 && w_acc1 && (r_j != 9'd255);
  assign w_n      = w_both ? 2'd2 : ((w_acc0 || w_acc1) ? 2'd1 : 2'd0);
  assign w_j_next = r_j + 9'(w_n);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    blk_ready = 1'b0;
    poly_done = 1'b0;
    done      = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD: begin
        blk_ready = 1'b1;
        if (blk_valid) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (w_step) begin
          if (w_j_next == J_FULL)      w_next = S_PDONE;
          else if (r_ptr == LAST_BYTE) w_next = S_LOAD;
        end
      end
      S_PDONE: begin
        // Hold here until the polynomial's final beat has left the output register.
        if (!r_coef_vld) begin
          poly_done = 1'b1;
          w_next    = ((r_poly_idx + POLY_W'(1)) < r_npolys) ? S_LOAD : S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk      <= '0;
      r_ptr      <= '0;
      r_j        <= '0;
      r_eta      <= ETA2;
      r_npolys   <= '0;
      r_poly_idx <= '0;
      r_coef_vld <= 1'b0;
      r_lane_en  <= '0;
      r_coef0    <= '0;
      r_coef1    <= '0;
      r_coef_idx <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_eta      <= eta_e'(eta_sel);
        r_npolys   <= (num_polys == '0) ? POLY_W'(1) : num_polys;
        r_poly_idx <= '0;
        r_j        <= '0;
      end
      if (r_state == S_LOAD && blk_valid) begin
        r_blk <= blk_data;
        r_ptr <= '0;
      end
      if (w_step) begin
        r_blk <= r_blk >> 8;
        r_ptr <= r_ptr + 8'd1;
        r_j   <= w_j_next;
        if (w_n != 2'd0) begin
          r_coef_vld <= 1'b1;
          r_lane_en  <= w_both ? 2'b11 : 2'b01;
          r_coef0    <= w_acc0 ? w_val0 : w_val1;
          r_coef1    <= w_both ? w_val1 : '0;
          r_coef_idx <= r_j[7:0];
        end else begin
          r_coef_vld <= 1'b0;
        end
      end else if (r_coef_vld && coef_ready) begin
        r_coef_vld <= 1'b0;
      end
      if (r_state == S_PDONE && !r_coef_vld) begin
        r_j        <= '0;
        r_poly_idx <= r_poly_idx + POLY_W'(1);
      end
    end
  end

  assign coef_valid   = r_coef_vld;
  assign coef_lane_en = r_lane_en;
  assign coef0        = r_coef0;
  assign coef1        = r_coef1;
  assign coef_idx     = r_coef_idx;
  assign poly_idx     = r_poly_idx;
endmodule
